// File: rtl/intersection_sched.sv
// Two-approach intersection scheduler: main street rests on green,
// side-vehicle and pedestrian requests are latched and served round-robin.
module intersection_sched #(
    parameter int GMIN  = 8,
    parameter int YEL   = 3,
    parameter int AR    = 2,
    parameter int SIDEG = 10,
    parameter int WALKT = 6,
    parameter int TW    = 8
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       Ped,
    input  logic       CarSide,
    output logic       MainG,
    output logic       MainY,
    output logic       MainR,
    output logic       SideG,
    output logic       SideY,
    output logic       SideR,
    output logic       Walk,
    output logic [2:0] State
);

    typedef enum logic [2:0] {
        S_MG  = 3'd0,
        S_MY  = 3'd1,
        S_ARA = 3'd2,
        S_SG  = 3'd3,
        S_SY  = 3'd4,
        S_ARB = 3'd5,
        S_WK  = 3'd6,
        S_BAD = 3'd7
    } state_e;

    localparam logic [TW-1:0] TMAX    = '1;
    localparam logic [TW-1:0] GMIN_L  = TW'(GMIN - 1);
    localparam logic [TW-1:0] YEL_L   = TW'(YEL - 1);
    localparam logic [TW-1:0] AR_L    = TW'(AR - 1);
    localparam logic [TW-1:0] SIDEG_L = TW'(SIDEG - 1);
    localparam logic [TW-1:0] WALKT_L = TW'(WALKT - 1);

    // last_q: 1 = pedestrian served most recently, 0 = side street
    localparam logic LAST_PED  = 1'b1;
    localparam logic LAST_SIDE = 1'b0;

    state_e        state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic          side_pend_q, side_pend_d;
    logic          ped_pend_q, ped_pend_d;
    logic          last_q, last_d;
    logic          enter_sg, enter_wk;
    logic          side_wins;

    assign side_wins = side_pend_q && (!ped_pend_q || last_q == LAST_PED);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_MG: begin
                if (t_q >= GMIN_L && (side_pend_q || ped_pend_q))
                    state_d = S_MY;
            end
            S_MY: begin
                if (t_q == YEL_L)
                    state_d = S_ARA;
            end
            S_ARA: begin
                if (t_q == AR_L)
                    state_d = side_wins ? S_SG : S_WK;
            end
            S_SG: begin
                if (t_q == SIDEG_L)
                    state_d = S_SY;
            end
            S_SY: begin
                if (t_q == YEL_L)
                    state_d = S_ARB;
            end
            S_WK: begin
                if (t_q == WALKT_L)
                    state_d = S_ARB;
            end
            S_ARB: begin
                if (t_q == AR_L)
                    state_d = S_MG;
            end
            default: state_d = S_MG;
        endcase
    end

    assign enter_sg = (state_d == S_SG) && (state_q != S_SG);
    assign enter_wk = (state_d == S_WK) && (state_q != S_WK);

    always_comb begin
        t_d = t_q;
        if (state_d != state_q)
            t_d = '0;
        else if (t_q != TMAX)
            t_d = t_q + 1'b1;
    end

    // Entering service clears the flag even if the request is still asserted.
    always_comb begin
        side_pend_d = side_pend_q;
        ped_pend_d  = ped_pend_q;
        last_d      = last_q;
        if (enter_sg)
            side_pend_d = 1'b0;
        else if (state_q != S_SG)
            side_pend_d = side_pend_q | CarSide;
        if (enter_wk)
            ped_pend_d = 1'b0;
        else if (state_q != S_WK)
            ped_pend_d = ped_pend_q | Ped;
        if (enter_sg)
            last_d = LAST_SIDE;
        else if (enter_wk)
            last_d = LAST_PED;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= S_MG;
            t_q         <= '0;
            side_pend_q <= 1'b0;
            ped_pend_q  <= 1'b0;
            last_q      <= LAST_PED;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            side_pend_q <= side_pend_d;
            ped_pend_q  <= ped_pend_d;
            last_q      <= last_d;
        end
    end

    always_comb begin
        MainG = 1'b0;
        MainY = 1'b0;
        MainR = 1'b0;
        SideG = 1'b0;
        SideY = 1'b0;
        SideR = 1'b0;
        Walk  = 1'b0;
        case (state_q)
            S_MG: begin
                MainG = 1'b1;
                SideR = 1'b1;
            end
            S_MY: begin
                MainY = 1'b1;
                SideR = 1'b1;
            end
            S_SG: begin
                MainR = 1'b1;
                SideG = 1'b1;
            end
            S_SY: begin
                MainR = 1'b1;
                SideY = 1'b1;
            end
            S_WK: begin
                MainR = 1'b1;
                SideR = 1'b1;
                Walk  = 1'b1;
            end
            default: begin
                MainR = 1'b1;
                SideR = 1'b1;
            end
        endcase
    end

    assign State = state_q;

    a_no_conflict: assert property (@(posedge CLK) disable iff (!RSTn)
        !(MainG && SideG));
    a_walk_red: assert property (@(posedge CLK) disable iff (!RSTn)
        Walk |-> (MainR && SideR));

endmodule

// File: tb/tb_intersection_sched.sv
// Randomized and directed bench for intersection_sched with a
// dwell-table reference model checked every cycle.
module tb_intersection_sched;

    localparam int GMIN  = 8;
    localparam int YEL   = 3;
    localparam int AR    = 2;
    localparam int SIDEG = 10;
    localparam int WALKT = 6;
    localparam int TW    = 8;
    localparam int TSAT  = (1 << TW) - 1;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic ped = 1'b0;
    logic car = 1'b0;
    logic mg, my, mr, sg, sy, sr, walk;
    logic [2:0] st;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    intersection_sched #(
        .GMIN(GMIN), .YEL(YEL), .AR(AR),
        .SIDEG(SIDEG), .WALKT(WALKT), .TW(TW)
    ) dut (
        .CLK(clk), .RSTn(rstn), .Ped(ped), .CarSide(car),
        .MainG(mg), .MainY(my), .MainR(mr),
        .SideG(sg), .SideY(sy), .SideR(sr),
        .Walk(walk), .State(st)
    );

    // Lamp colour per state: 0 = green, 1 = yellow, 2 = red
    localparam int MAIN_L [7] = '{0, 1, 2, 2, 2, 2, 2};
    localparam int SIDE_L [7] = '{2, 2, 2, 0, 1, 2, 2};

    int ms, mt, ecount, mnx;
    bit msp, mpp, mlast;

    function automatic int dwell(input int s);
        case (s)
            0: return GMIN;
            1: return YEL;
            2: return AR;
            3: return SIDEG;
            4: return YEL;
            5: return AR;
            6: return WALKT;
            default: return 1;
        endcase
    endfunction

    function automatic int next_of(input int s, input int t,
                                   input bit sp, input bit pp,
                                   input bit lastp);
        if (s == 0)
            return (t >= GMIN - 1 && (sp || pp)) ? 1 : 0;
        if (s > 6)
            return 0;
        if (t != dwell(s) - 1)
            return s;
        case (s)
            1: return 2;
            2: return (sp && (!pp || lastp)) ? 3 : 6;
            3: return 4;
            4: return 5;
            6: return 5;
            default: return 0;
        endcase
    endfunction

    always_comb mnx = next_of(ms, mt, msp, mpp, mlast);

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ms     <= 0;
            mt     <= 0;
            msp    <= 1'b0;
            mpp    <= 1'b0;
            mlast  <= 1'b1;
            ecount <= 0;
        end else begin
            ms     <= mnx;
            mt     <= (mnx != ms) ? 0 : ((mt == TSAT) ? mt : mt + 1);
            msp    <= (mnx == 3 && ms != 3) ? 1'b0
                    : (ms != 3) ? (msp | car) : msp;
            mpp    <= (mnx == 6 && ms != 6) ? 1'b0
                    : (ms != 6) ? (mpp | ped) : mpp;
            mlast  <= (mnx == 3 && ms != 3) ? 1'b0
                    : (mnx == 6 && ms != 6) ? 1'b1 : mlast;
            ecount <= ecount + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            logic [9:0] exp_v, act_v;
            exp_v = {MAIN_L[ms] == 0, MAIN_L[ms] == 1, MAIN_L[ms] == 2,
                     SIDE_L[ms] == 0, SIDE_L[ms] == 1, SIDE_L[ms] == 2,
                     ms == 6, 3'(ms)};
            act_v = {mg, my, mr, sg, sy, sr, walk, st};
            chk("model_cycle", int'(act_v), int'(exp_v));
        end
    end

    task automatic go_edge(input int n);
        int guard;
        guard = 0;
        while (ecount < n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (ecount != n) begin
            errors++;
            $display("FAIL go_edge: reached %0d expected %0d", ecount, n);
        end
    endtask

    task automatic do_reset(input bit p, input bit c);
        @(negedge clk);
        rstn = 1'b0;
        ped  = p;
        car  = c;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #1;
        chk("rst_state", int'(st), 0);
        chk("rst_lamps", int'({mg, my, mr, sg, sy, sr, walk}), 7'b1000010);

        // Idle: no requests for 200 cycles
        do_reset(1'b0, 1'b0);
        go_edge(200);
        chk("idle_state", int'(st), 0);
        chk("idle_mg", int'(mg), 1);

        // Side request pulse sampled at edge 20
        do_reset(1'b0, 1'b0);
        go_edge(19);
        car = 1'b1;
        go_edge(20);
        car = 1'b0;
        chk("A_mg20", int'(st), 0);
        go_edge(21); chk("A_my21", int'(st), 1);
        go_edge(24); chk("A_ara24", int'(st), 2);
        go_edge(26); chk("A_sg26", int'(st), 3);
        chk("A_sideg26", int'(sg), 1);
        go_edge(35); chk("A_sideg35", int'(sg), 1);
        go_edge(36); chk("A_sy36", int'(st), 4);
        go_edge(39); chk("A_arb39", int'(st), 5);
        go_edge(41); chk("A_mg41", int'(st), 0);

        // Pedestrian pulse at edge 2, then ignored/latched pulses
        do_reset(1'b0, 1'b0);
        go_edge(1);
        ped = 1'b1;
        go_edge(2);
        ped = 1'b0;
        go_edge(7); chk("B_mg7", int'(st), 0);
        go_edge(8); chk("B_my8", int'(st), 1);
        go_edge(13); chk("B_wk13", int'(st), 6);
        chk("B_walk_red", int'({walk, mr, sr}), 3'b111);
        go_edge(14);
        ped = 1'b1;
        go_edge(15);
        ped = 1'b0;
        go_edge(18); chk("B_walk18", int'(walk), 1);
        go_edge(19); chk("B_arb19", int'(st), 5);
        chk("B_walk19", int'(walk), 0);
        go_edge(40); chk("D_wk_ped_ignored", int'(st), 0);
        car = 1'b1;
        go_edge(41);
        car = 1'b0;
        go_edge(47); chk("D_sg47", int'(st), 3);
        go_edge(49);
        ped = 1'b1;
        go_edge(50);
        ped = 1'b0;
        go_edge(57); chk("D_sy57", int'(st), 4);
        go_edge(62); chk("D_mg62", int'(st), 0);
        go_edge(69); chk("D_mg69", int'(st), 0);
        go_edge(70); chk("D_my70", int'(st), 1);
        go_edge(75); chk("D_wk75", int'(st), 6);

        // Both requests held from reset release
        do_reset(1'b1, 1'b1);
        go_edge(8); chk("C_my8", int'(st), 1);
        go_edge(13); chk("C_sg13", int'(st), 3);
        go_edge(28); chk("C_mg28", int'(st), 0);
        go_edge(30);
        ped = 1'b0;
        car = 1'b0;
        go_edge(35); chk("C_mg35", int'(st), 0);
        go_edge(36); chk("C_my36", int'(st), 1);
        go_edge(41); chk("C_wk41", int'(st), 6);

        // Asynchronous reset in the middle of side green
        do_reset(1'b0, 1'b0);
        go_edge(19);
        car = 1'b1;
        go_edge(20);
        car = 1'b0;
        go_edge(27);
        ped = 1'b1;
        go_edge(28);
        ped = 1'b0;
        go_edge(30);
        chk("R_in_sg", int'(st), 3);
        #1 rstn = 1'b0;
        #1;
        chk("R_state", int'(st), 0);
        chk("R_lamps", int'({mg, my, mr, sg, sy, sr, walk}), 7'b1000010);
        chk("R_side_pend", int'(dut.side_pend_q), 0);
        chk("R_ped_pend", int'(dut.ped_pend_q), 0);
        #1 rstn = 1'b1;
        go_edge(20);
        chk("R_idle_after", int'(st), 0);

        // Random request traffic
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) != 0) begin
                ped = ($urandom_range(0, 24) == 0);
                car = ($urandom_range(0, 17) == 0);
            end
        end
        ped = 1'b0;
        car = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
